pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary-output stage placed directly downstream of the GPIO PWM generator. It takes the generator's per-channel PWM waveforms and drives a high-side/low-side output pair per channel, inserting a programmable dead band in which both sides are off at every edge. A sticky fault input forces all outputs off. It sits between the PWM generator and the GPIO pad multiplexing.

## Interface

Parameters:
- CHANNELS, 3, number of PWM channels; matches the generator's output width.
- DT_WIDTH, 8, width of the dead-time count.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- pwm_i  in  CHANNELS  raw PWM waveform from the generator, one bit per channel.
- enable_i  in  CHANNELS  per-channel output enable.
- deadtime_i  in  DT_WIDTH  dead-time count D, shared by all channels.
- fault_i  in  1  external fault request.
- fault_clr_i  in  1  clears the latched fault.
- out_hi_o  out  CHANNELS  high-side drive, registered.
- out_lo_o  out  CHANNELS  low-side drive, registered.
- fault_o  out  1  latched fault flag, registered.

## Operation

- Sampling: `pwm_i` is registered once into `pwm_q` and is not otherwise synchronised; the generator is in the same clock domain.
- Each channel has an independent 5-state FSM:
  - OFF: both sides low.
  - LO: low side on.
  - HI: high side on.
  - DT_HI: dead band before the high side turns on.
  - DT_LO: dead band before the low side turns on.
- Each channel has a DT_WIDTH-bit down-counter `cnt`.
- Channel gate: `gate = enable_i[n] & ~fault_o & ~fault_i`.
- FSM transitions, evaluated in priority order:
  - Any state with `gate` = 0 → OFF.
  - OFF with `gate` = 1: `pwm_q` = 1 → DT_HI, otherwise → DT_LO. `cnt` is loaded with `deadtime_i`. Re-enabling therefore always inserts a dead band.
  - LO with `pwm_q` = 1 → DT_HI, `cnt` ← `deadtime_i`.
  - HI with `pwm_q` = 0 → DT_LO, `cnt` ← `deadtime_i`.
  - DT_HI:
    - `pwm_q` = 0 → DT_LO, `cnt` ← `deadtime_i`. The dead band restarts and a short pulse is absorbed.
    - Else `cnt` = 0 → HI.
    - Else `cnt` ← `cnt` − 1.
  - DT_LO: symmetric to DT_HI, with target LO and abort on `pwm_q` = 1.
- Outputs:
  - `out_hi_o[n]` = 1 exactly when the registered state is HI.
  - `out_lo_o[n]` = 1 exactly when the registered state is LO.
  - Both outputs are registered alongside the state, so they are glitch-free and never 1 simultaneously.
- Fault latch:
  - `fault_o` is set on any cycle with `fault_i` = 1.
  - It is cleared by `fault_clr_i` = 1 only when `fault_i` = 0; set wins when both are asserted.
- `deadtime_i` is sampled only on a `cnt` load. Changing it mid-band does not affect the band in progress.
- Counter arithmetic is unsigned. `cnt` never wraps: decrement happens only when `cnt` ≠ 0.

## Timing

- Reset: all states OFF, `cnt` = 0, `pwm_q` = 0; `out_hi_o` = 0, `out_lo_o` = 0, `fault_o` = 0.
- Event latency for a `pwm_i` change sampled at edge k (`pwm_q` updated at k):
  - The active side turns off at edge k+1.
  - The opposite side turns on at edge k+D+2.
  - Both-low dead band = D+1 cycles; minimum 1 cycle when D = 0.
- A `pwm_i` pulse that toggles back at or before the last dead-band cycle never reaches the output; the band restarts in the other direction.
- Disable:
  - `enable_i[n]` falling sampled at edge k → both outputs of that channel low after edge k.
  - Same single-edge response for `fault_i`, affecting all channels.
- `fault_o` asserts at the same edge that `fault_i` is sampled high.
- Recovery after `fault_clr_i`: OFF → dead band → normal operation. The first output edge is D+1 cycles after the gate reopens.
- Simultaneous disable and PWM edge: disable wins; the channel goes to OFF.
- Reset mid dead-band: the channel goes straight to OFF; no output is driven.

## Test plan

- Reset, then D = 3, enable ch0, `pwm_i[0]` 0→1 held → `out_lo_o[0]` falls 1 cycle after `pwm_q` rises; `out_hi_o[0]` rises 5 cycles after `pwm_q` rises; both low for exactly 4 cycles.
- D = 0 with a 50% square wave of period 20 → each transition shows exactly 1 both-low cycle; `out_hi_o` & `out_lo_o` never both 1 over 1000 cycles.
- D = 5 with `pwm_i` pulses 1–5 cycles wide while in LO → `out_hi_o` stays 0. A 7-cycle pulse produces `out_hi_o` high for 1 cycle.
- Assert `fault_i` for 1 cycle while channels are in HI → all outputs 0 from the next edge; `fault_o` = 1 and stays 1. Then `fault_clr_i` → `fault_o` = 0; each channel resumes after D+1 dead cycles.
- Assert `fault_i` and `fault_clr_i` in the same cycle → `fault_o` = 1.
- Change `deadtime_i` 3→10 in the middle of a band → the current band stays 4 cycles; the next band is 11 cycles.
- Toggle `enable_i[1]` off/on while `pwm_i[1]` = 1 → outputs low for 1 cycle beyond the disable, then D+1 cycles of dead band, then `out_hi_o[1]` = 1. Channels 0 and 2 are unaffected throughout.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary hi/lo drive per PWM channel with a programmable dead band and a sticky fault kill.
// Latency: output side change D+2 edges after pwm_i is sampled, disable/fault kill next edge; no backpressure.
module pwm_deadtime #(
  parameter int CHANNELS = 3,
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] pwm_i,
  input  logic [CHANNELS-1:0] enable_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  input  logic                fault_i,
  input  logic                fault_clr_i,
  output logic [CHANNELS-1:0] out_hi_o,
  output logic [CHANNELS-1:0] out_lo_o,
  output logic                fault_o
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LO,
    ST_HI,
    ST_DT_HI,
    ST_DT_LO
  } state_t;

  state_t                     state_q [CHANNELS];
  state_t                     state_d [CHANNELS];
  logic [CHANNELS-1:0][DT_WIDTH-1:0] cnt_q;
  logic [CHANNELS-1:0][DT_WIDTH-1:0] cnt_d;
  logic [CHANNELS-1:0]        pwm_q;
  logic [CHANNELS-1:0]        gate;

  // fault_i is folded in directly so a fault kills outputs on the same edge it is sampled
  assign gate = enable_i & {CHANNELS{~fault_o & ~fault_i}};

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      if (!gate[n]) begin
        state_d[n] = ST_OFF;
      end else begin
        case (state_q[n])
          ST_OFF: begin
            state_d[n] = pwm_q[n] ? ST_DT_HI : ST_DT_LO;
            cnt_d[n]   = deadtime_i;
          end
          ST_LO: begin
            if (pwm_q[n]) begin
              state_d[n] = ST_DT_HI;
              cnt_d[n]   = deadtime_i;
            end
          end
          ST_HI: begin
            if (!pwm_q[n]) begin
              state_d[n] = ST_DT_LO;
              cnt_d[n]   = deadtime_i;
            end
          end
          ST_DT_HI: begin
            // an early reversal restarts the band toward the other side
            if (!pwm_q[n]) begin
              state_d[n] = ST_DT_LO;
              cnt_d[n]   = deadtime_i;
            end else if (cnt_q[n] == '0) begin
              state_d[n] = ST_HI;
            end else begin
              cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
            end
          end
          ST_DT_LO: begin
            if (pwm_q[n]) begin
              state_d[n] = ST_DT_HI;
              cnt_d[n]   = deadtime_i;
            end else if (cnt_q[n] == '0) begin
              state_d[n] = ST_LO;
            end else begin
              cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
            end
          end
          default: state_d[n] = ST_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q    <= '0;
      out_hi_o <= '0;
      out_lo_o <= '0;
      fault_o  <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n] <= ST_OFF;
        cnt_q[n]   <= '0;
      end
    end else begin
      pwm_q <= pwm_i;
      if (fault_i) begin
        fault_o <= 1'b1;
      end else if (fault_clr_i) begin
        fault_o <= 1'b0;
      end
      // outputs decoded from next state so they register together with it
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n]  <= state_d[n];
        cnt_q[n]    <= cnt_d[n];
        out_hi_o[n] <= (state_d[n] == ST_HI);
        out_lo_o[n] <= (state_d[n] == ST_LO);
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: dead-band timing, pulse absorption, fault latch, enable toggling.
module tb_pwm_deadtime;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] pwm_i;
  logic [2:0] enable_i;
  logic [7:0] deadtime_i;
  logic       fault_i;
  logic       fault_clr_i;
  logic [2:0] out_hi_o;
  logic [2:0] out_lo_o;
  logic       fault_o;

  int n_cmp = 0;
  int n_err = 0;
  logic overlap = 1'b0;
  logic watch_ch02 = 1'b0;
  logic ch02_drop = 1'b0;

  pwm_deadtime #(.CHANNELS(3), .DT_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pwm_i      (pwm_i),
    .enable_i   (enable_i),
    .deadtime_i (deadtime_i),
    .fault_i    (fault_i),
    .fault_clr_i(fault_clr_i),
    .out_hi_o   (out_hi_o),
    .out_lo_o   (out_lo_o),
    .fault_o    (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    if ((out_hi_o & out_lo_o) != 3'b000) overlap = 1'b1;
    if (watch_ch02 && !(out_hi_o[0] && out_hi_o[2])) ch02_drop = 1'b1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts both-low cycles on one channel until the target side turns on; -1 if it never does.
  task automatic band(input int ch, input bit to_hi, input string tag, input int exp);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      if (to_hi ? out_hi_o[ch] : out_lo_o[ch]) done = 1'b1;
      else if (!out_hi_o[ch] && !out_lo_o[ch]) n++;
    end
    chk(tag, done ? n : -1, exp);
  endtask

  initial begin
    int hi_cnt;
    int dead_cnt;
    int others_lo_bad;

    rst_i = 1'b1; pwm_i = '0; enable_i = '0; deadtime_i = 8'd0;
    fault_i = 1'b0; fault_clr_i = 1'b0;
    tick(); tick();
    chk("rst_hi", int'(out_hi_o), 0);
    chk("rst_lo", int'(out_lo_o), 0);
    chk("rst_fault", int'(fault_o), 0);
    rst_i = 1'b0;
    tick();
    chk("disabled_lo", int'(out_lo_o), 0);

    // enable from OFF always passes through a dead band
    deadtime_i = 8'd3; enable_i = 3'b111;
    tick(); tick(); tick(); tick();
    chk("en_band_lo", int'(out_lo_o), 0);
    tick();
    chk("en_lo_on", int'(out_lo_o), 7);

    // pwm 0->1 on ch0 with D=3
    pwm_i[0] = 1'b1;
    tick();
    chk("t1_lo_k", int'(out_lo_o), 7);
    tick();
    chk("t1_lo_k1", int'(out_lo_o), 6);
    chk("t1_hi_k1", int'(out_hi_o), 0);
    band(0, 1'b1, "t1_band", 3);
    chk("t1_hi", int'(out_hi_o), 1);

    pwm_i[0] = 1'b0;
    tick();
    band(0, 1'b0, "t1_back", 4);

    // D=5: pulses of 1..5 cycles vanish, 7 cycles gives one HI cycle
    deadtime_i = 8'd5;
    for (int w = 1; w <= 7; w++) begin
      if (w == 6) continue;
      hi_cnt = 0;
      pwm_i[0] = 1'b1;
      for (int i = 0; i < w; i++) begin
        tick();
        if (out_hi_o[0]) hi_cnt++;
      end
      pwm_i[0] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (out_hi_o[0]) hi_cnt++;
      end
      chk($sformatf("pulse_w%0d_hi", w), hi_cnt, (w == 7) ? 1 : 0);
      chk($sformatf("pulse_w%0d_lo", w), int'(out_lo_o[0]), 1);
    end

    // dead-time change mid-band only affects the next band
    deadtime_i = 8'd3;
    pwm_i[0] = 1'b1;
    tick(); tick();
    deadtime_i = 8'd10;
    band(0, 1'b1, "dt_keep", 3);
    pwm_i[0] = 1'b0;
    tick();
    band(0, 1'b0, "dt_new", 11);

    // D=0 square wave, period 20, for 1000 cycles
    deadtime_i = 8'd0;
    dead_cnt = 0;
    others_lo_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 10 == 0) pwm_i[0] = ~pwm_i[0];
      tick();
      if (!out_hi_o[0] && !out_lo_o[0]) dead_cnt++;
      if (!(out_lo_o[1] && out_lo_o[2])) others_lo_bad++;
    end
    chk("sq_dead", dead_cnt, 100);
    chk("sq_others", others_lo_bad, 0);
    chk("sq_overlap", int'(overlap), 0);

    // fault while all channels are HI
    deadtime_i = 8'd3;
    pwm_i = 3'b111;
    tick();
    band(0, 1'b1, "flt_pre", 4);
    chk("flt_pre_hi", int'(out_hi_o), 7);
    fault_i = 1'b1;
    tick();
    chk("flt_hi", int'(out_hi_o), 0);
    chk("flt_lo", int'(out_lo_o), 0);
    chk("flt_set", int'(fault_o), 1);
    fault_i = 1'b0;
    tick(); tick(); tick();
    chk("flt_sticky", int'(fault_o), 1);
    chk("flt_sticky_hi", int'(out_hi_o), 0);
    fault_clr_i = 1'b1;
    tick();
    chk("flt_clr", int'(fault_o), 0);
    fault_clr_i = 1'b0;
    band(0, 1'b1, "flt_recover", 4);
    chk("flt_rec_hi", int'(out_hi_o), 7);

    // set wins over clear
    fault_i = 1'b1; fault_clr_i = 1'b1;
    tick();
    chk("sim_fault", int'(fault_o), 1);
    chk("sim_hi", int'(out_hi_o), 0);
    fault_i = 1'b0; fault_clr_i = 1'b0;
    tick();
    chk("sim_hold", int'(fault_o), 1);
    fault_clr_i = 1'b1;
    tick();
    chk("sim_clr", int'(fault_o), 0);
    fault_clr_i = 1'b0;
    band(0, 1'b1, "sim_recover", 4);
    chk("sim_rec_hi", int'(out_hi_o), 7);

    // enable toggle on ch1 while pwm is high
    watch_ch02 = 1'b1;
    enable_i = 3'b101;
    tick();
    chk("en1_off_hi", int'(out_hi_o), 5);
    chk("en1_off_lo", int'(out_lo_o), 0);
    enable_i = 3'b111;
    band(1, 1'b1, "en1_band", 4);
    watch_ch02 = 1'b0;
    chk("en1_others", int'(ch02_drop), 0);
    chk("en1_hi", int'(out_hi_o), 7);

    // reset in the middle of a dead band
    pwm_i = 3'b000;
    tick(); tick();
    chk("rstmid_band", int'(out_hi_o | out_lo_o), 0);
    rst_i = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("rstmid_hi", int'(out_hi_o), 0);
    chk("rstmid_lo", int'(out_lo_o), 0);
    rst_i = 1'b0;

    chk("overlap", int'(overlap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
